// File: rtl/pong_game_ctrl.sv
// Pong game controller: tick divider, serve/play/point/over state machine,
// ball motion with wall and paddle reflection, and score keeping.
module pong_game_ctrl #(
  parameter int TICK_DIV    = 262144,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7,
  parameter int PADDLE_H    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_n,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic       tick,
  output logic       paddle_en,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       game_over
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SERVE_DELAY + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(TICK_DIV - 2);
  localparam logic [SW-1:0] SRV_LOAD = SW'(SERVE_DELAY);
  localparam logic [3:0]    WIN     = 4'(WIN_SCORE);
  localparam logic [10:0]   PH      = 11'(PADDLE_H);

  localparam logic [9:0] X_CTR = 10'd316;
  localparam logic [9:0] Y_CTR = 10'd236;
  localparam logic [9:0] X_PL  = 10'd24;
  localparam logic [9:0] X_PR  = 10'd608;
  localparam logic [9:0] X_MAX = 10'd632;
  localparam logic [9:0] Y_MAX = 10'd472;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t        st, st_nx;
  logic [CW-1:0] cnt;
  logic [9:0]    bx, by, bx_nx, by_nx;
  logic          dx, dy, dx_nx, dy_nx;
  logic [3:0]    sl, sr, sl_nx, sr_nx;
  logic [SW-1:0] srv, srv_nx;
  logic          pt_right, pt_right_nx;

  logic [10:0]   by_w, pl_w, pr_w;
  logic          hit_l, hit_r;
  logic          ndx, ndy;
  logic [3:0]    sc;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  // Tick divider; tick is registered so it is high while cnt == TICK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      tick <= (cnt == CNT_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      bx       <= X_CTR;
      by       <= Y_CTR;
      dx       <= 1'b1;
      dy       <= 1'b1;
      sl       <= '0;
      sr       <= '0;
      srv      <= '0;
      pt_right <= 1'b0;
    end else begin
      st       <= st_nx;
      bx       <= bx_nx;
      by       <= by_nx;
      dx       <= dx_nx;
      dy       <= dy_nx;
      sl       <= sl_nx;
      sr       <= sr_nx;
      srv      <= srv_nx;
      pt_right <= pt_right_nx;
    end
  end

  // Paddle overlap in 11 bits so ball_y+8 and paddle_y+PADDLE_H never wrap.
  assign by_w  = {1'b0, by};
  assign pl_w  = {1'b0, paddle_l_y};
  assign pr_w  = {1'b0, paddle_r_y};
  assign hit_l = (by_w + 11'd8 > pl_w) && (by_w < pl_w + PH);
  assign hit_r = (by_w + 11'd8 > pr_w) && (by_w < pr_w + PH);

  always_comb begin
    st_nx       = st;
    bx_nx       = bx;
    by_nx       = by;
    dx_nx       = dx;
    dy_nx       = dy;
    sl_nx       = sl;
    sr_nx       = sr;
    srv_nx      = srv;
    pt_right_nx = pt_right;
    ndx         = dx;
    ndy         = dy;
    sc          = '0;

    if (tick) begin
      case (st)
        S_IDLE: begin
          bx_nx = X_CTR;
          by_nx = Y_CTR;
          if (!start_n) begin
            st_nx  = S_SERVE;
            sl_nx  = '0;
            sr_nx  = '0;
            srv_nx = SRV_LOAD;
          end
        end

        S_SERVE: begin
          bx_nx = X_CTR;
          by_nx = Y_CTR;
          if (srv != '0) srv_nx = srv - SW'(1);
          if (srv <= SW'(1)) st_nx = S_PLAY;
        end

        S_PLAY: begin
          if (bx == '0 && !dx) begin
            pt_right_nx = 1'b1;
            st_nx       = S_POINT;
          end else if (bx == X_MAX && dx) begin
            pt_right_nx = 1'b0;
            st_nx       = S_POINT;
          end else begin
            // Reflections resolve first; the move then uses the new direction.
            if (by == '0 && !dy)    ndy = 1'b1;
            if (by == Y_MAX && dy)  ndy = 1'b0;
            if (bx == X_PL && !dx && hit_l) ndx = 1'b1;
            if (bx == X_PR &&  dx && hit_r) ndx = 1'b0;
            dx_nx = ndx;
            dy_nx = ndy;
            bx_nx = ndx ? bx + 10'd1 : bx - 10'd1;
            by_nx = ndy ? by + 10'd1 : by - 10'd1;
          end
        end

        S_POINT: begin
          if (pt_right) begin
            sc    = sat_inc(sr);
            sr_nx = sc;
          end else begin
            sc    = sat_inc(sl);
            sl_nx = sc;
          end
          if (sc == WIN) begin
            st_nx = S_OVER;
          end else begin
            st_nx  = S_SERVE;
            bx_nx  = X_CTR;
            by_nx  = Y_CTR;
            srv_nx = SRV_LOAD;
            dx_nx  = ~pt_right;
          end
        end

        S_OVER: begin
          if (!start_n) begin
            st_nx  = S_SERVE;
            sl_nx  = '0;
            sr_nx  = '0;
            dx_nx  = 1'b1;
            bx_nx  = X_CTR;
            by_nx  = Y_CTR;
            srv_nx = SRV_LOAD;
          end
        end

        default: st_nx = S_IDLE;
      endcase
    end
  end

  assign ball_x    = bx;
  assign ball_y    = by;
  assign score_l   = sl;
  assign score_r   = sr;
  assign state     = st;
  assign game_over = (st == S_OVER);
  assign paddle_en = tick && (st == S_PLAY);

endmodule
